uart_tx_framer: RTL

UART transmit framer: accepts one parallel data word per valid/ready handshake and serialises it onto a single line. Each frame is a start bit, then DATA_BITS data bits LSB-first, then an optional parity bit, then 1 or 2 stop bits. It is the transmit-side counterpart of the receive path's frame error checker. It generates the parity that the receiver checks, using the same parity_type encoding and the same bit order, and sits between the host-side TX buffer and the serial pin.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_framer_if.sv | 13 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_framer.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, TX state encoding and the parity helper.
// The RX frame error checker uses the same encoding and helper.
package uart_pkg;

  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  localparam int         MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Callers zero-extend narrower words; zero bits do not change the reduction.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0] parity_type);
    logic p;
    case (parity_type)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~^data;
      default:     p = 1'b1;
    endcase
    return p;
  endfunction

  function automatic logic parity_type_ok(input logic [1:0] parity_type);
    return (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Host-side word handshake into the UART transmit framer.
// Word and parity type are only meaningful in the cycle tx_valid && tx_ready.
interface uart_tx_framer_if #(parameter int DATA_BITS = 8);
  import uart_pkg::*;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           parity_type;

  modport master (output tx_valid, output tx_data, output parity_type, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input parity_type, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: bit_end is a registered pulse in the last cycle of every bit period.
// restart makes the following cycle the first of a fresh period; no backpressure.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (restart || (cnt == LAST)) cnt_nxt = '0;
  end

  // bit_end is looked ahead from cnt_nxt so it lines up with cnt == LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_end <= (cnt_nxt == LAST);
    end
  end
endmodule

// File: rtl/uart_tx_framer.sv
// UART TX framer: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits; tx falls one cycle after accept.
// tx_ready only in IDLE or the final stop cycle, so back-to-back frames leave no idle gap.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_framer_if.slave host,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            cfg_err
);
  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           ptype_q;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 last_stop;
  logic                 accept;

  assign last_stop     = (state == TX_STOP) && (stop_idx == 1'(STOP_BITS - 1)) && bit_end;
  assign host.tx_ready = !reset && ((state == TX_IDLE) || last_stop);
  assign accept        = host.tx_valid && host.tx_ready;
  assign tx_done       = last_stop;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      cfg_err  <= 1'b0;
      data_q   <= '0;
      shift_q  <= '0;
      ptype_q  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      cfg_err <= accept && (PARITY_EN != 0) && !parity_type_ok(host.parity_type);
      // An accept in the last stop cycle takes priority and chains straight into START.
      if (accept) begin
        state   <= TX_START;
        tx      <= 1'b0;
        tx_busy <= 1'b1;
        data_q  <= host.tx_data;
        shift_q <= host.tx_data;
        ptype_q <= host.parity_type;
      end else if (bit_end) begin
        case (state)
          TX_START: begin
            state   <= TX_DATA;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_idx <= '0;
          end
          TX_DATA: begin
            if (bit_idx == LAST_IDX) begin
              stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= TX_PARITY;
                tx    <= parity_bit(MAX_DATA_BITS'(data_q), ptype_q);
              end else begin
                state <= TX_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          TX_PARITY: begin
            state    <= TX_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
          TX_STOP: begin
            if (last_stop) begin
              state   <= TX_IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= TX_IDLE;
        endcase
      end
    end
  end
endmodule
